fifo_frame_packer: RTL and testbench
====================================

FIFO_FRAME_PACKER -- requirements
Module: fifo_frame_packer

Interface
REQ-001 Parameter TRAILER_EN, default 1; 1 appends an XOR checksum byte to each frame, 0 omits it.
REQ-002 wclk  in  1  write-domain clock; all logic is clocked on the rising edge.
REQ-003 wrst  in  1  reset, asynchronous, active-low; clock wclk.
REQ-004 s_valid  in  1  upstream word valid.
REQ-005 s_ready  out  1  upstream word accepted when s_valid and s_ready are both high.
REQ-006 s_data  in  32  upstream word; bytes are sent LSB first.
REQ-007 s_sop  in  1  marks the first word of a frame.
REQ-008 s_len  in  4  frame word count minus 1 (0..15); sampled only with the accepted SOP word.
REQ-009 fifo_full  in  1  write-side full flag from the async FIFO; combinational input.
REQ-010 fifo_w_en  out  1  FIFO write strobe.
REQ-011 fifo_data  out  8  FIFO write byte.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 frame_done  out  1  one-cycle pulse after the last byte of a frame is written.
REQ-014 protocol_err  out  1  one-cycle pulse on a framing violation.

Function
REQ-015 States SHALL be IDLE, HDR, PAY, LOAD and TRL.
REQ-016 fifo_w_en SHALL equal (state in {HDR, PAY, TRL}) and !fifo_full; a byte transfers only on a cycle where fifo_w_en is high.
REQ-017 While fifo_full is high, fifo_data and all state SHALL hold unchanged, with no byte skipped or duplicated.
REQ-018 IDLE behaviour:
- s_ready = 1.
- s_valid and s_sop: capture s_data into word_q, words_left = s_len, len_q = s_len, byte_idx = 0, chk = 0, then go to HDR.
- s_valid and !s_sop: drop the word and pulse protocol_err.
REQ-019 HDR: fifo_data = (len_q + 1) * 4 (8-bit, range 4..64); on transfer, go to PAY.
REQ-020 PAY: fifo_data = word_q byte byte_idx; on transfer, chk ^= byte and byte_idx increments (2-bit, wraps).
REQ-021 PAY with byte_idx == 3 on transfer:
- words_left == 0: go to TRL, or to IDLE when TRAILER_EN = 0.
- Otherwise: s_ready = 1 that cycle (combinational on fifo_full).
  - s_valid high: load the word, words_left -= 1, byte_idx = 0, stay in PAY (no bubble).
  - s_valid low: go to LOAD.
REQ-022 s_ready SHALL be 0 in HDR, in TRL, and in PAY except the cycle defined in REQ-021.
REQ-023 LOAD:
- s_ready = 1; fifo_w_en = 0.
- On s_valid: load the word, words_left -= 1, byte_idx = 0, go to PAY.
- An s_sop seen in LOAD pulses protocol_err; the word is still taken as payload.
REQ-024 TRL: fifo_data = chk; on transfer, go to IDLE.
REQ-025 frame_done SHALL be registered and high for exactly the cycle after the final byte transfer (trailer, or last payload byte when TRAILER_EN = 0).
REQ-026 fifo_data SHALL be 0 in IDLE and LOAD.
REQ-027 A frame SHALL occupy 1 + 4*(s_len+1) + TRAILER_EN FIFO entries.

Reset
REQ-028 On wrst low, asynchronously:
- state = IDLE.
- word_q, len_q, words_left, byte_idx and chk = 0.
- frame_done = 0, protocol_err = 0.
- Hence fifo_w_en = 0, fifo_data = 0, busy = 0, s_ready = 1 after release.
REQ-029 Reset mid-frame SHALL abandon the frame with no further FIFO writes; the next frame starts cleanly from IDLE.

Structure
REQ-030 A shared package SHALL hold:
- the state enum;
- WORD_W = 32, BYTE_W = 8, LEN_W = 4;
- the header-byte function (len+1)*4.
REQ-031 The block SHALL be a single module with no sub-modules; all outputs derive from registers, except fifo_w_en and the REQ-021 s_ready term.

Verification
REQ-032 Single frame, len 0, word 0x44332211, fifo_full = 0: FIFO receives 0x04, 0x11, 0x22, 0x33, 0x44, 0x44 on consecutive cycles; frame_done pulses once.
REQ-033 len 1, words 0x04030201 and 0x08070605 offered back-to-back: 10 consecutive fifo_w_en cycles, bytes 0x08, 0x01..0x08, trailer 0x08.
REQ-034 Same frame with fifo_full high for 5 cycles during byte 0x03: fifo_data holds 0x03, no write occurs, and the sequence resumes intact.
REQ-035 Second word delayed 4 cycles: LOAD entered, fifo_w_en = 0 throughout, s_ready = 1; the sequence continues correctly afterwards.
REQ-036 s_valid without s_sop in IDLE: word dropped, protocol_err pulses once, no FIFO write.
REQ-037 wrst asserted after the 2nd payload byte: fifo_w_en drops immediately; the next frame (len 0, word 0xAABBCCDD) yields 0x04, 0xDD, 0xCC, 0xBB, 0xAA, 0x00.

Source files
------------

// File: rtl/fifo_frame_packer_pkg.sv
// Shared types and constants for the frame packer: FSM states, bus widths, header encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_frame_packer_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        LOAD = 3'd3,
        TRL  = 3'd4
    } state_t;

    // Header byte is the payload size in bytes: (len + 1) * 4, range 4..64.
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [LEN_W-1:0] len);
        logic [BYTE_W-1:0] words;
        words = {{(BYTE_W-LEN_W){1'b0}}, len} + 8'd1;
        return {words[BYTE_W-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/fifo_frame_packer.sv
// Serialises 32-bit upstream words into a byte stream for an async FIFO: header, payload LSB-first, optional XOR trailer.
// Latency: header byte offered the cycle after the SOP word is accepted; payload words stream with no bubble when available.
// Backpressure: fifo_full freezes all state and fifo_data; upstream is only ready in IDLE, LOAD, or when the last byte of a word drains.
//
// Ports:
//   wclk, wrst         clock and async active-low reset
//   s_valid/s_ready    upstream word handshake; s_data word, s_sop first word, s_len word count minus 1
//   fifo_full          FIFO write-side full flag (combinational)
//   fifo_w_en/_data    FIFO write strobe and byte
//   busy               FSM not idle
//   frame_done         one-cycle pulse after the final byte of a frame is written
//   protocol_err       one-cycle pulse on a framing violation
module fifo_frame_packer
    import fifo_frame_packer_pkg::*;
#(
    parameter bit TRAILER_EN = 1'b1
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_sop,
    input  logic [LEN_W-1:0]  s_len,
    input  logic              fifo_full,
    output logic              fifo_w_en,
    output logic [BYTE_W-1:0] fifo_data,
    output logic              busy,
    output logic              frame_done,
    output logic              protocol_err
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic              frame_done_d;
    logic              protocol_err_d;
    logic [BYTE_W-1:0] pay_byte;

    assign pay_byte  = word_q[{byte_idx_q, 3'b000} +: BYTE_W];
    assign fifo_w_en = ((state_q == HDR) || (state_q == PAY) || (state_q == TRL)) && !fifo_full;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        len_d          = len_q;
        words_left_d   = words_left_q;
        byte_idx_d     = byte_idx_q;
        chk_d          = chk_q;
        frame_done_d   = 1'b0;
        protocol_err_d = 1'b0;
        s_ready        = 1'b0;
        fifo_data      = '0;

        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_sop) begin
                        word_d       = s_data;
                        words_left_d = s_len;
                        len_d        = s_len;
                        byte_idx_d   = 2'd0;
                        chk_d        = '0;
                        state_d      = HDR;
                    end else begin
                        protocol_err_d = 1'b1;
                    end
                end
            end
            HDR: begin
                fifo_data = hdr_byte(len_q);
                if (fifo_w_en) state_d = PAY;
            end
            PAY: begin
                fifo_data = pay_byte;
                if (fifo_w_en) begin
                    chk_d      = chk_q ^ pay_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (words_left_q == '0) begin
                            if (TRAILER_EN) begin
                                state_d = TRL;
                            end else begin
                                state_d      = IDLE;
                                frame_done_d = 1'b1;
                            end
                        end else begin
                            // Ready only while the last byte drains, so the next
                            // word can follow without an idle cycle.
                            s_ready = 1'b1;
                            if (s_valid) begin
                                word_d       = s_data;
                                words_left_d = words_left_q - 4'd1;
                                byte_idx_d   = 2'd0;
                            end else begin
                                state_d = LOAD;
                            end
                        end
                    end
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // A stray SOP mid-frame is flagged but still consumed as payload.
                    protocol_err_d = s_sop;
                    word_d         = s_data;
                    words_left_d   = words_left_q - 4'd1;
                    byte_idx_d     = 2'd0;
                    state_d        = PAY;
                end
            end
            TRL: begin
                fifo_data = chk_q;
                if (fifo_w_en) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            len_q        <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            chk_q        <= '0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            len_q        <= len_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            chk_q        <= chk_d;
            frame_done   <= frame_done_d;
            protocol_err <= protocol_err_d;
        end
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Scoreboard bench for fifo_frame_packer: directed frames with hand-computed byte streams.
// Latency: n/a.
// Backpressure: bench drives fifo_full stalls and delayed upstream words.
module tb_fifo_frame_packer;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_sop;
    logic [3:0]  s_len;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data;
    logic        busy;
    logic        frame_done;
    logic        protocol_err;

    fifo_frame_packer #(.TRAILER_EN(1'b1)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_sop        (s_sop),
        .s_len        (s_len),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data    (fifo_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .protocol_err (protocol_err)
    );

    always #5 wclk = ~wclk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;
    int wr_cnt = 0, run_len = 0, max_run = 0, done_cnt = 0, err_cnt = 0;
    int wr0, done0, err0;
    bit inj_en = 1'b0;
    int held_ok = 0;
    int load_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: every FIFO write is checked against the scoreboard.
    always @(negedge wclk) begin
        if (fifo_w_en) begin
            wr_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: byte 0x%0h, expected no write", fifo_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("fifo_byte", {24'd0, fifo_data}, {24'd0, mon_e});
            end
        end else begin
            run_len = 0;
        end
        if (frame_done) done_cnt++;
        if (protocol_err) err_cnt++;
    end

    // Stall injector: holds fifo_full for 5 cycles once byte 0x03 is presented.
    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (inj_en && busy && fifo_data == 8'h03) begin
                inj_en    = 1'b0;
                fifo_full = 1'b1;
                repeat (5) begin
                    @(negedge wclk);
                    if (!fifo_w_en && fifo_data == 8'h03) held_ok++;
                end
                @(posedge wclk);
                #1;
                fifo_full = 1'b0;
            end
        end
    end

    // Caller must be at posedge+1.
    task automatic send_word(input logic [31:0] d, input logic sop, input logic [3:0] len);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sop   = sop;
        s_len   = len;
        @(negedge wclk);
        while (!s_ready && n < 200) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 200) timeout_fail("send_word");
        @(posedge wclk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 100) begin
            @(negedge wclk);
            if (frame_done) break;
            n++;
        end
        if (n >= 100) timeout_fail(name);
        @(posedge wclk);
        #1;
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        while (n < 100) begin
            @(negedge wclk);
            if (busy && s_ready && !fifo_w_en) break;
            n++;
        end
        if (n >= 100) timeout_fail(name);
    endtask

    task automatic snap();
        wr0     = wr_cnt;
        done0   = done_cnt;
        err0    = err_cnt;
        max_run = 0;
    endtask

    task automatic push_len1_frame();
        exp_q.push_back(8'h08);
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h08);
    endtask

    initial begin
        wrst = 1'b0; s_valid = 1'b0; s_data = '0; s_sop = 1'b0; s_len = '0; fifo_full = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_s_ready",      {31'd0, s_ready},      32'd1);
        check("rst_busy",         {31'd0, busy},         32'd0);
        check("rst_fifo_w_en",    {31'd0, fifo_w_en},    32'd0);
        check("rst_fifo_data",    {24'd0, fifo_data},    32'd0);
        check("rst_frame_done",   {31'd0, frame_done},   32'd0);
        check("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
        wrst = 1'b1;
        @(posedge wclk);
        #1;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("post_rst_busy",    {31'd0, busy},    32'd0);

        // Single-word frame.
        snap();
        exp_q.push_back(8'h04); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h44);
        send_word(32'h44332211, 1'b1, 4'd0);
        wait_done("len0_done");
        check("len0_writes",  32'(wr_cnt - wr0),     32'd6);
        check("len0_run",     32'(max_run),          32'd6);
        check("len0_done_n",  32'(done_cnt - done0), 32'd1);
        check("len0_idle",    {31'd0, busy},         32'd0);

        // Two words back-to-back: no bubble.
        snap();
        push_len1_frame();
        send_word(32'h04030201, 1'b1, 4'd1);
        send_word(32'h08070605, 1'b0, 4'd0);
        wait_done("b2b_done");
        check("b2b_writes", 32'(wr_cnt - wr0),     32'd10);
        check("b2b_run",    32'(max_run),          32'd10);
        check("b2b_done_n", 32'(done_cnt - done0), 32'd1);
        check("b2b_err_n",  32'(err_cnt - err0),   32'd0);

        // Same frame with a 5-cycle full stall on byte 0x03.
        snap();
        push_len1_frame();
        held_ok = 0;
        inj_en  = 1'b1;
        send_word(32'h04030201, 1'b1, 4'd1);
        send_word(32'h08070605, 1'b0, 4'd0);
        wait_done("stall_done");
        check("stall_hold",   32'(held_ok),          32'd5);
        check("stall_writes", 32'(wr_cnt - wr0),     32'd10);
        check("stall_done_n", 32'(done_cnt - done0), 32'd1);

        // Second word late: LOAD holds with ready high and no writes.
        snap();
        push_len1_frame();
        load_ok = 0;
        send_word(32'h04030201, 1'b1, 4'd1);
        wait_load("load_enter");
        repeat (4) begin
            @(negedge wclk);
            if (busy && s_ready && !fifo_w_en && fifo_data == 8'h00) load_ok++;
        end
        check("load_hold", 32'(load_ok), 32'd4);
        @(posedge wclk);
        #1;
        send_word(32'h08070605, 1'b0, 4'd0);
        wait_done("load_done");
        check("load_writes", 32'(wr_cnt - wr0),     32'd10);
        check("load_done_n", 32'(done_cnt - done0), 32'd1);
        check("load_err_n",  32'(err_cnt - err0),   32'd0);

        // Word without SOP in IDLE is dropped.
        snap();
        send_word(32'hDEADBEEF, 1'b0, 4'd3);
        repeat (3) @(posedge wclk);
        #1;
        check("nosop_err_n",  32'(err_cnt - err0), 32'd1);
        check("nosop_writes", 32'(wr_cnt - wr0),   32'd0);
        check("nosop_busy",   {31'd0, busy},       32'd0);

        // SOP seen in LOAD: flagged but used as payload.
        snap();
        push_len1_frame();
        send_word(32'h04030201, 1'b1, 4'd1);
        wait_load("sopload_enter");
        @(posedge wclk);
        #1;
        send_word(32'h08070605, 1'b1, 4'd9);
        wait_done("sopload_done");
        check("sopload_err_n",  32'(err_cnt - err0),   32'd1);
        check("sopload_writes", 32'(wr_cnt - wr0),     32'd10);
        check("sopload_done_n", 32'(done_cnt - done0), 32'd1);

        // Reset after the second payload byte abandons the frame.
        snap();
        exp_q.push_back(8'h04); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        send_word(32'h44332211, 1'b1, 4'd0);
        begin
            int n = 0;
            while (wr_cnt < wr0 + 3 && n < 100) begin
                @(negedge wclk);
                #1;
                n++;
            end
            if (n >= 100) timeout_fail("midrst_wait");
        end
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        #1;
        check("midrst_w_en",    {31'd0, fifo_w_en}, 32'd0);
        check("midrst_busy",    {31'd0, busy},      32'd0);
        check("midrst_data",    {24'd0, fifo_data}, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready},   32'd1);
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b1;
        repeat (3) @(posedge wclk);
        #1;
        check("midrst_writes", 32'(wr_cnt - wr0),     32'd3);
        check("midrst_done_n", 32'(done_cnt - done0), 32'd0);

        snap();
        exp_q.push_back(8'h04); exp_q.push_back(8'hDD); exp_q.push_back(8'hCC);
        exp_q.push_back(8'hBB); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
        send_word(32'hAABBCCDD, 1'b1, 4'd0);
        wait_done("after_rst_done");
        check("after_rst_writes", 32'(wr_cnt - wr0),     32'd6);
        check("after_rst_done_n", 32'(done_cnt - done0), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
